// File: rtl/line_mem_resp.sv
// line_mem_resp: line-oriented memory with fixed access latency, req/gnt handshake and abortable requests.
// Optional LINE_MEM_RESP_STATS_EN adds completed read/write counters rd_cnt and wr_cnt.
module line_mem_resp #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int LATENCY       = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [ADDR_LEN-1:0]                        addr,
    input  logic                                       rd_req,
    input  logic                                       wr_req,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]             wr_line,
    output logic [(32<<LINE_ADDR_LEN)-1:0]             rd_line,
    output logic                                       gnt,
    output logic [(32<<(ADDR_LEN+LINE_ADDR_LEN))-1:0]  ram_cell
`ifdef LINE_MEM_RESP_STATS_EN
    ,
    output logic [31:0]                                rd_cnt,
    output logic [31:0]                                wr_cnt
`endif
);
    localparam int LW = 32 << LINE_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN+4:0] ZOFF = '0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [7:0]          cnt;
    logic                wr_op;
    logic [ADDR_LEN-1:0] addr_l;
    logic [LW-1:0]       line_l;
    logic                req_l;

    assign req_l = wr_op ? wr_req : rd_req;

    // Handshake FSM, wait counter, storage and read line; write wins when both requests are high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            cnt      <= '0;
            wr_op    <= 1'b0;
            addr_l   <= '0;
            line_l   <= '0;
            rd_line  <= '0;
            ram_cell <= '0;
`ifdef LINE_MEM_RESP_STATS_EN
            rd_cnt   <= '0;
            wr_cnt   <= '0;
`endif
        end else begin
            gnt <= 1'b0;
            case (state)
                IDLE: if (rd_req || wr_req) begin
                    wr_op  <= wr_req;
                    addr_l <= addr;
                    line_l <= wr_line;
                    cnt    <= 8'(LATENCY - 1);
                    state  <= BUSY;
                end
                BUSY: if (!req_l) begin
                    state <= IDLE;
                end else if (cnt == 8'd0) begin
                    if (wr_op) ram_cell[{addr_l, ZOFF} +: LW] <= line_l;
                    else       rd_line <= ram_cell[{addr_l, ZOFF} +: LW];
`ifdef LINE_MEM_RESP_STATS_EN
                    if (wr_op) wr_cnt <= wr_cnt + 32'd1;
                    else       rd_cnt <= rd_cnt + 32'd1;
`endif
                    gnt   <= 1'b1;
                    state <= DONE;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_mem_resp.sv
// tb_line_mem_resp: directed self-checking bench for line_mem_resp at LATENCY=4, ADDR_LEN=9, LINE_ADDR_LEN=3.
module tb_line_mem_resp;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [8:0]        addr = '0;
    logic              rd_req = 1'b0;
    logic              wr_req = 1'b0;
    logic [255:0]      wr_line = '0;
    logic [255:0]      rd_line;
    logic              gnt;
    logic [131071:0]   ram_cell;
`ifdef LINE_MEM_RESP_STATS_EN
    logic [31:0]       rd_cnt, wr_cnt;
`endif
    int vecs = 0;
    int errs = 0;

    line_mem_resp dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
        .wr_line(wr_line), .rd_line(rd_line), .gnt(gnt), .ram_cell(ram_cell)
`ifdef LINE_MEM_RESP_STATS_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input logic [31:0] b);
        for (int i = 0; i < 8; i++) mk[i*32 +: 32] = b + 32'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises a request in the current cycle, scrambles addr/data after acceptance, returns edges until gnt
    task automatic do_req(input logic w, input logic [8:0] a, input logic [255:0] d, output int n);
        addr = a;
        wr_line = d;
        wr_req = w;
        rd_req = !w;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) begin
                addr = ~a;
                wr_line = ~d;
            end
        end while (!gnt && n < 20);
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    // Read request dropped after two BUSY cycles; reports whether any gnt appeared
    task automatic do_abort(input logic [8:0] a, output logic g);
        addr = a;
        rd_req = 1'b1;
        g = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            g |= gnt;
        end
        rd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            g |= gnt;
        end
    endtask

    task automatic test_reset();
        #3;
        vecs++; if (gnt !== 1'b0) begin errs++; $display("FAIL reset_gnt got %b want 0", gnt); end
        vecs++; if (rd_line !== '0) begin errs++; $display("FAIL reset_rd_line got %h want 0", rd_line); end
        vecs++; if (ram_cell !== '0) begin errs++; $display("FAIL reset_ram nonzero storage"); end
`ifdef LINE_MEM_RESP_STATS_EN
        vecs++; if (rd_cnt !== 0 || wr_cnt !== 0) begin errs++; $display("FAIL reset_cnt got %0d/%0d want 0/0", rd_cnt, wr_cnt); end
`endif
        #9 rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        int n;
        do_req(1'b1, 9'h012, mk(32'h100), n);
        vecs++; if (n !== 5) begin errs++; $display("FAIL wr_latency got %0d want 5", n); end
        step();
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (ram_cell[(32'h90 + i)*32 +: 32] !== 32'h100 + 32'(i)) begin
                errs++; $display("FAIL ram_word_%0h got %h want %h", 32'h90 + i, ram_cell[(32'h90 + i)*32 +: 32], 32'h100 + 32'(i));
            end
        end
        do_req(1'b0, 9'h012, '0, n);
        vecs++; if (n !== 5) begin errs++; $display("FAIL rd_latency got %0d want 5", n); end
        vecs++; if (rd_line !== mk(32'h100)) begin errs++; $display("FAIL rd_data got %h want %h", rd_line, mk(32'h100)); end
        step();
        vecs++; if (gnt !== 1'b0) begin errs++; $display("FAIL gnt_one_cycle got %b want 0", gnt); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_req(1'b1, 9'h1F0, mk(32'h200), n);
        step();
        do_req(1'b1, 9'h0A5, mk(32'h300), n);
        vecs++; if (n !== 5) begin errs++; $display("FAIL swap_out_latency got %0d want 5", n); end
        step();
        do_req(1'b0, 9'h1F0, '0, n);
        vecs++; if (n !== 5) begin errs++; $display("FAIL swap_in_latency got %0d want 5", n); end
        vecs++; if (rd_line !== mk(32'h200)) begin errs++; $display("FAIL swap_in_data got %h want %h", rd_line, mk(32'h200)); end
        step();
        vecs++; if (rd_line !== mk(32'h200) || gnt !== 1'b0) begin errs++; $display("FAIL swap_in_hold got %h gnt %b want %h gnt 0", rd_line, gnt, mk(32'h200)); end
        vecs++; if (ram_cell[32'h528*32 +: 32] !== 32'h300) begin errs++; $display("FAIL swap_out_word got %h want 300", ram_cell[32'h528*32 +: 32]); end
    endtask

    task automatic test_abort();
        int n;
        logic g;
        do_req(1'b1, 9'h003, mk(32'h400), n);
        step();
        do_abort(9'h003, g);
        vecs++; if (g !== 1'b0) begin errs++; $display("FAIL abort_gnt got %b want 0", g); end
        vecs++; if (rd_line !== mk(32'h200)) begin errs++; $display("FAIL abort_rd_line got %h want %h", rd_line, mk(32'h200)); end
        do_req(1'b0, 9'h003, '0, n);
        vecs++; if (n !== 5) begin errs++; $display("FAIL post_abort_latency got %0d want 5", n); end
        vecs++; if (rd_line !== mk(32'h400)) begin errs++; $display("FAIL post_abort_data got %h want %h", rd_line, mk(32'h400)); end
        step();
    endtask

    task automatic test_simultaneous();
        int n;
        addr = 9'h044;
        wr_line = mk(32'h500);
        rd_req = 1'b1;
        wr_req = 1'b1;
        n = 0;
        do begin step(); n++; end while (!gnt && n < 20);
        wr_req = 1'b0;
        wr_line = '1;
        vecs++; if (n !== 5) begin errs++; $display("FAIL simul_wr_latency got %0d want 5", n); end
        vecs++; if (rd_line !== mk(32'h400)) begin errs++; $display("FAIL simul_write_first got %h want %h", rd_line, mk(32'h400)); end
        n = 0;
        do begin step(); n++; end while (!gnt && n < 20);
        rd_req = 1'b0;
        vecs++; if (n !== 6) begin errs++; $display("FAIL simul_rd_delay got %0d want 6", n); end
        vecs++; if (rd_line !== mk(32'h500)) begin errs++; $display("FAIL simul_rd_data got %h want %h", rd_line, mk(32'h500)); end
        vecs++; if (ram_cell[32'h220*32 +: 32] !== 32'h500) begin errs++; $display("FAIL simul_word got %h want 500", ram_cell[32'h220*32 +: 32]); end
        step();
    endtask

    task automatic test_reset_busy();
        logic g;
        addr = 9'h100;
        wr_line = mk(32'h600);
        wr_req = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        wr_req = 1'b0;
        #2 rst = 1'b0;
        g = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            g |= gnt;
        end
        vecs++; if (g !== 1'b0) begin errs++; $display("FAIL rst_busy_gnt got %b want 0", g); end
        vecs++; if (ram_cell[32'h800*32 +: 256] !== '0) begin errs++; $display("FAIL rst_busy_line got %h want 0", ram_cell[32'h800*32 +: 256]); end
        vecs++; if (ram_cell !== '0) begin errs++; $display("FAIL rst_busy_ram nonzero storage"); end
        vecs++; if (rd_line !== '0) begin errs++; $display("FAIL rst_busy_rd_line got %h want 0", rd_line); end
`ifdef LINE_MEM_RESP_STATS_EN
        vecs++; if (rd_cnt !== 0 || wr_cnt !== 0) begin errs++; $display("FAIL rst_busy_cnt got %0d/%0d want 0/0", rd_cnt, wr_cnt); end
`endif
    endtask

`ifdef LINE_MEM_RESP_STATS_EN
    task automatic test_stats();
        int n;
        logic g;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 9'(i), mk(32'h700), n);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            do_req(1'b0, 9'(i), '0, n);
            step();
        end
        do_abort(9'h002, g);
        vecs++; if (wr_cnt !== 32'd3) begin errs++; $display("FAIL stats_wr got %0d want 3", wr_cnt); end
        vecs++; if (rd_cnt !== 32'd2) begin errs++; $display("FAIL stats_rd got %0d want 2", rd_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_abort();
        test_simultaneous();
        test_reset_busy();
`ifdef LINE_MEM_RESP_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/line_mem_resp.md
LINE_MEM_RESP -- requirements
Module: line_mem_resp

Interface
REQ-001 SHALL have parameter LINE_ADDR_LEN, default 3, log2 of 32-bit words per line.
REQ-002 SHALL have parameter ADDR_LEN, default 9, line-address width; capacity is 2^ADDR_LEN lines.
REQ-003 SHALL have parameter LATENCY, default 4, wait cycles per access; legal range 1..255.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port addr, input, ADDR_LEN, line address of the request.
REQ-007 SHALL have port rd_req, input, 1, line read request, held until gnt.
REQ-008 SHALL have port wr_req, input, 1, line write request, held until gnt.
REQ-009 SHALL have port wr_line, input, 32 x 2^LINE_ADDR_LEN, line data to write.
REQ-010 SHALL have port rd_line, output, 32 x 2^LINE_ADDR_LEN, registered read line.
REQ-011 SHALL have port gnt, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port ram_cell, output, 32 x 2^(ADDR_LEN+LINE_ADDR_LEN), live word view of storage, word index = {line addr, word offset}.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE.
REQ-014 IDLE: a request is accepted at the edge where rd_req or wr_req is sampled high; addr, op and wr_line are latched; wait counter is loaded with LATENCY-1; next state is BUSY.
REQ-015 When both requests are high in IDLE, the write SHALL be accepted; the read stays pending and is accepted in a later IDLE cycle.
REQ-016 BUSY: the counter decrements each edge; at the edge where it is 0 and the latched request is still high, the access is performed, gnt is set and the next state is DONE.
REQ-017 Req first high in cycle c SHALL give gnt high in exactly cycle c+LATENCY+1 only.
REQ-018 Write access: the latched wr_line SHALL be stored into line latched_addr at the access edge; ram_cell reflects it from the next cycle on.
REQ-019 Read access: rd_line SHALL load line latched_addr at the access edge and hold that value until the next completed read.
REQ-020 DONE: gnt high for that one cycle; next state IDLE unconditionally; requests seen in DONE are not accepted.
REQ-021 The requester may drop its request during BUSY (abort): the next state SHALL be IDLE with no storage update, no rd_line change and no gnt.
REQ-022 Changes to addr or wr_line after acceptance SHALL be ignored.
REQ-023 Back-to-back operation: a request high in the cycle after DONE SHALL be accepted at that cycle's edge.

Reset
REQ-024 rst SHALL force IDLE, gnt=0, rd_line all zero, counter 0 and every storage word 0, asynchronously and at any point, including mid-BUSY.
REQ-025 An access in flight at reset SHALL be discarded; no gnt follows reset release until a new request completes.

Configuration
REQ-026 Macro LINE_MEM_RESP_STATS_EN defined: 32-bit outputs rd_cnt and wr_cnt SHALL exist, reset to 0, and increment by 1 on each completed read or write (gnt edge); they wrap modulo 2^32; aborts do not count.
REQ-027 LINE_MEM_RESP_STATS_EN undefined: rd_cnt, wr_cnt and their counters SHALL be absent; all other behaviour is identical.

Verification (LATENCY=4, ADDR_LEN=9, LINE_ADDR_LEN=3)
REQ-028 Write then read: wr_req, addr=0x012, wr_line words 0x100..0x107, held until gnt -> gnt in cycle c+5; read of 0x012 -> rd_line=0x100..0x107; ram_cell[0x90..0x97] match.
REQ-029 Swap-out then swap-in: write 0x0A5 gnt, then rd_req 0x1F0 in the next cycle -> accepted immediately; read gnt exactly 5 cycles later; rd_line stable in the cycle after gnt.
REQ-030 Abort: rd_req 0x003 dropped after 2 BUSY cycles -> no gnt; rd_line unchanged; next request completes with normal latency.
REQ-031 Simultaneous requests: rd_req=wr_req=1 at addr 0x044 -> write completes first; read then returns the written data.
REQ-032 Reset mid-BUSY: rst pulse during write to 0x100 -> no gnt; ram_cell line 0x100 = 0; rd_line=0; stats counters 0 when enabled.
REQ-033 Stats (macro on): 3 writes, 2 reads, 1 abort -> wr_cnt=3, rd_cnt=2.
